// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the uart_tx arbiter slice.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_e;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned ID_W      = $clog2(N_REQ_DEF);

  // Width able to hold 0..timeout-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first request after ptr, with wrap; optional single-id mask.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         mask_en,
  input  logic [W-1:0] mask_id,
  output logic [N-1:0] onehot,
  output logic [W-1:0] id,
  output logic         any
);

  logic [N-1:0] eff;
  logic [W-1:0] sel;

  always_comb begin
    eff = req;
    if (mask_en) begin
      eff          = '0;
      eff[mask_id] = req[mask_id];
    end
  end

  always_comb begin
    onehot = '0;
    id     = '0;
    any    = 1'b0;
    sel    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      sel = W'((int'(ptr) + int'(k)) % int'(N));
      if (!any && eff[sel]) begin
        any         = 1'b1;
        onehot[sel] = 1'b1;
        id          = sel;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte producers.
// Define UART_TX_ARB_PKT_LOCK_EN to add req_last and hold the grant for a whole packet.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
`ifdef UART_TX_ARB_PKT_LOCK_EN
  input  logic [N_REQ-1:0]         req_last,
`endif
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     active,
  output logic                     err_timeout
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = cnt_w(BUSY_TIMEOUT);
  localparam logic [IW-1:0] PTR_RST  = IW'(N_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  arb_state_e state, next;
  logic [IW-1:0]    ptr;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_id;
  logic             pick_any;
  logic             mask_en;
  logic             accept;
  logic [7:0]       acc_byte;

`ifdef UART_TX_ARB_PKT_LOCK_EN
  logic locked;
  logic acc_last;
  assign mask_en  = locked;
  assign acc_last = |(req_last & pick_oh);
`else
  assign mask_en = 1'b0;
`endif

  rr_pick #(
    .N(N_REQ),
    .W(IW)
  ) u_pick (
    .req    (req_valid),
    .ptr    (ptr),
    .mask_en(mask_en),
    .mask_id(grant_id),
    .onehot (pick_oh),
    .id     (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    acc_byte = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) acc_byte = acc_byte | req_data[8*i +: 8];
    end
  end

  always_comb begin
    next        = state;
    req_ready   = '0;
    tx_start    = 1'b0;
    err_timeout = 1'b0;
    accept      = 1'b0;
    active      = (state != IDLE);
    case (state)
      IDLE: begin
        // ready is gated by rst so nothing is accepted while reset is held
        if (pick_any && !tx_busy && !rst) begin
          req_ready = pick_oh;
          accept    = 1'b1;
          next      = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start = 1'b1;
        next     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          next = WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          err_timeout = 1'b1;
          next        = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= PTR_RST;
      cnt      <= '0;
      tx_data  <= '0;
      grant_id <= '0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
      locked   <= 1'b0;
`endif
    end else begin
      state <= next;
      if (accept) begin
        tx_data  <= acc_byte;
        grant_id <= pick_id;
`ifdef UART_TX_ARB_PKT_LOCK_EN
        // ptr only moves when a packet ends, so the locked requester keeps its turn
        if (acc_last) begin
          ptr    <= pick_id;
          locked <= 1'b0;
        end else begin
          locked <= 1'b1;
        end
`else
        ptr <= pick_id;
`endif
      end
`ifdef UART_TX_ARB_PKT_LOCK_EN
      if (err_timeout) begin
        locked <= 1'b0;
        ptr    <= grant_id;
      end
`endif
      if (state == LAUNCH) begin
        cnt <= '0;
      end else if (state == WAIT_BUSY && !tx_busy) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx stub and a cycle model.
module tb_uart_tx_arbiter;
  localparam int unsigned N     = 4;
  localparam int unsigned BT    = 8;
  localparam int unsigned FRAME = 40;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           active;
  logic           err_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(N),
    .BUSY_TIMEOUT(BT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
`ifdef UART_TX_ARB_PKT_LOCK_EN
    .req_last   (req_last),
`endif
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .active     (active),
    .err_timeout(err_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_seq(input string name, input int got[$], input int exp[$]);
    chk({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk($sformatf("%s[%0d]", name, i), got[i], exp[i]);
  endtask

  // ---------------- producers ----------------
  logic [7:0] q_data[N][$];
  logic       q_last[N][$];
  logic [N-1:0] prod_hs;

  always @(posedge clk) begin
    prod_hs = req_valid & req_ready;
    for (int i = 0; i < N; i++)
      if (prod_hs[i] && q_data[i].size() > 0) begin
        q_data[i].delete(0);
        q_last[i].delete(0);
      end
    #1;
    for (int i = 0; i < N; i++) begin
      if (q_data[i].size() > 0) begin
        req_valid[i]     = 1'b1;
        req_data[8*i+:8] = q_data[i][0];
        req_last[i]      = q_last[i][0];
      end else begin
        req_valid[i]     = 1'b0;
        req_data[8*i+:8] = '0;
        req_last[i]      = 1'b0;
      end
    end
  end

  // ---------------- uart_tx stub ----------------
  logic stub_en = 1'b1, ext_busy = 1'b0, stub_busy = 1'b0;
  int   stub_cnt = 0;
  logic [7:0] stub_byte = '0;
  int   rx_log[$];

  assign tx_busy = (stub_en & stub_busy) | ext_busy;

  always @(posedge clk) begin
    if (rst) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
    end else if (stub_busy) begin
      if (stub_cnt == FRAME - 1) begin
        stub_busy <= 1'b0;
        rx_log.push_back(int'(stub_byte));
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end else if (stub_en && tx_start) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 0;
      stub_byte <= tx_data;
    end
  end

  // ---------------- model + compare ----------------
  logic rst_seen = 1'b1;
  always @(posedge clk) rst_seen <= rst;

  int   m_ptr = N - 1, m_age = 0, m_gid = 0, m_lock_id = 0;
  bit   m_idle = 1, m_seen = 0, m_lock = 0;
  logic [7:0] m_data = '0;
  int   cyc = 0, start_cyc = 0, ready0100_cnt = 0;
  int   err_lat[$];
  int   grant_log[$];
  logic [N-1:0] e_ready, mv;
  bit   e_start, e_err, nxt_idle;
  int   w;

  function automatic int rr_winner(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst_seen) begin
      m_ptr = N - 1; m_idle = 1; m_gid = 0; m_data = '0; m_lock = 0;
    end
    e_ready = '0; e_start = 0; e_err = 0; nxt_idle = m_idle; w = -1;
    if (m_idle) begin
      mv = m_lock ? (req_valid & (N'(1) << m_lock_id)) : req_valid;
      w  = rr_winner(mv, m_ptr);
      if (!rst && !tx_busy && w >= 0) e_ready = N'(1) << w;
    end else begin
      m_age++;
      e_start = (m_age == 1);
      if (m_age >= 2) begin
        if (!m_seen) begin
          if (tx_busy) m_seen = 1;
          else if (m_age == BT + 1) begin e_err = 1; nxt_idle = 1; end
        end else if (!tx_busy) nxt_idle = 1;
      end
    end

    chk("req_ready", req_ready, e_ready);
    chk("tx_start", tx_start, e_start);
    chk("err_timeout", err_timeout, e_err);
    chk("active", active, !m_idle);
    chk("grant_id", grant_id, m_gid);
    chk("tx_data", tx_data, m_data);
    if (tx_start) chk("start_while_busy", tx_busy, 0);

    if (req_ready == 4'b0100) ready0100_cnt++;
    if (tx_start) start_cyc = cyc;
    if (err_timeout) err_lat.push_back(cyc - start_cyc);

    if (e_ready != '0) begin
      m_data = req_data[8*w +: 8];
      m_gid  = w;
      grant_log.push_back(w);
      m_idle = 0; m_age = 0; m_seen = 0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
      if (req_last[w]) begin m_ptr = w; m_lock = 0; end
      else begin m_lock = 1; m_lock_id = w; end
`else
      m_ptr = w;
`endif
    end else if (!m_idle) begin
      m_idle = nxt_idle;
    end
    if (e_err) begin m_lock = 0; m_ptr = m_gid; end
  end

  // ---------------- stimulus ----------------
  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (q_data[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic wait_drain();
    int n = 0, idle_run = 0;
    while (idle_run < 3 && n < 3000) begin
      @(negedge clk);
      n++;
      if (queues_empty() && m_idle && !tx_busy) idle_run++;
      else idle_run = 0;
    end
    if (idle_run < 3) begin
      checks++; errors++;
      $display("FAIL drain_timeout cycles=%0d required=idle", n);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    q_data[r].push_back(d);
    q_last[r].push_back(l);
  endtask

  task automatic clear_logs();
    grant_log.delete(); rx_log.delete(); err_lat.delete();
  endtask

  initial begin
    int n;
    // T1: reset held 2 cycles with every requester valid
    for (int i = 0; i < N; i++) push(i, 8'h20 + 8'(i), 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_drain();
    chk_seq("t1_grants", grant_log, '{0, 1, 2, 3});
    chk_seq("t1_line", rx_log, '{32'h20, 32'h21, 32'h22, 32'h23});

    // T3: all requesters valid, refilled once
    clear_logs();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      push(i, 8'h10 + 8'(i), 1'b1);
      push(i, 8'h10 + 8'(i), 1'b1);
    end
    wait_drain();
    chk_seq("t3_line", rx_log, '{32'h10, 32'h11, 32'h12, 32'h13, 32'h10, 32'h11, 32'h12, 32'h13});

    // T2: single requester
    clear_logs();
    @(negedge clk);
    ready0100_cnt = 0;
    push(2, 8'hA5, 1'b1);
    wait_drain();
    chk_seq("t2_grants", grant_log, '{2});
    chk_seq("t2_line", rx_log, '{32'hA5});
    chk("t2_ready_cycles", ready0100_cnt, 1);

    // T4: busy held externally, then uart never responds
    clear_logs();
    @(posedge clk); #1 ext_busy = 1'b1; stub_en = 1'b0;
    @(negedge clk);
    push(1, 8'h55, 1'b1);
    push(1, 8'h66, 1'b1);
    repeat (6) @(negedge clk);
    chk("t4_no_accept_busy", grant_log.size(), 0);
    @(posedge clk); #1 ext_busy = 1'b0;
    wait_drain();
    chk_seq("t4_grants", grant_log, '{1, 1});
    chk_seq("t4_err_latency", err_lat, '{8, 8});
    chk("t4_line_len", rx_log.size(), 0);

    // T5: reset during WAIT_DONE
    clear_logs();
    @(posedge clk); #1 stub_en = 1'b1;
    @(negedge clk);
    push(1, 8'h77, 1'b1);
    n = 0;
    while (!tx_busy && n < 200) begin @(negedge clk); n++; end
    if (!tx_busy) begin
      checks++; errors++;
      $display("FAIL t5_busy_wait cycles=%0d required=busy", n);
    end
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_active", active, 0);
    chk("t5_grant_id", grant_id, 0);
    chk("t5_tx_data", tx_data, 0);
    chk("t5_tx_busy", tx_busy, 0);
    push(0, 8'h30, 1'b1);
    push(2, 8'h32, 1'b1);
    wait_drain();
    chk_seq("t5_grants", grant_log, '{1, 0, 2});
    chk_seq("t5_line", rx_log, '{32'h30, 32'h32});

    // T6: req0 sends a 3-byte packet while req1 stays valid
    clear_logs();
    @(negedge clk);
    push(0, 8'hB0, 1'b0); push(0, 8'hB1, 1'b0); push(0, 8'hB2, 1'b1);
    push(1, 8'hC0, 1'b1); push(1, 8'hC1, 1'b1); push(1, 8'hC2, 1'b1);
    wait_drain();
`ifdef UART_TX_ARB_PKT_LOCK_EN
    chk_seq("t6_grants", grant_log, '{0, 0, 0, 1, 1, 1});
    chk_seq("t6_line", rx_log, '{32'hB0, 32'hB1, 32'hB2, 32'hC0, 32'hC1, 32'hC2});
`else
    chk_seq("t6_grants", grant_log, '{0, 1, 0, 1, 0, 1});
    chk_seq("t6_line", rx_log, '{32'hB0, 32'hC0, 32'hB1, 32'hC1, 32'hB2, 32'hC2});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
